// File: rtl/spi_slave_sync_pkg.sv
// Shared definitions for the clk-synchronous SPI slave: mode encodings, FSM states and
// the bit-counter width helper.
package spi_slave_sync_pkg;

  // SPI mode encoding {CPOL, CPHA}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  typedef enum logic {
    StIdle,
    StActive
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// N-stage synchroniser for an asynchronous input with rise/fall pulses taken from the
// last two stages.
module sync_edge_det #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  // sync_q[0] is the newest sample, sync_q[STAGES-1] the oldest
  logic [STAGES-1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q    = sync_q[STAGES-1];
  assign rise = sync_q[STAGES-2] & ~sync_q[STAGES-1];
  assign fall = ~sync_q[STAGES-2] & sync_q[STAGES-1];

endmodule

// File: rtl/spi_slave_sync.sv
// System-clock-synchronous SPI slave: oversampled SCLK/CS_N/MOSI, all four CPOL/CPHA
// modes, multi-word frames, valid/ready handshakes on both directions.
module spi_slave_sync
  import spi_slave_sync_pkg::*;
#(
  parameter int unsigned WIDTH       = 13,
  parameter bit          CPOL        = 1'b0,
  parameter bit          CPHA        = 1'b0,
  parameter bit          MSB_FIRST   = 1'b1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             sclk,
  input  logic             cs_n,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             rx_overrun,
  output logic             tx_underrun,
  output logic             busy
);

  localparam int unsigned CntW          = cnt_width(WIDTH);
  localparam logic [1:0]  Mode          = {CPOL, CPHA};
  localparam bit          SampleLeading = (Mode == MODE0) || (Mode == MODE2);

  logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s;
  logic unused_sclk_q, unused_cs_q, unused_mosi_rise, unused_mosi_fall;

  sync_edge_det #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk  (clk),
    .clr  (clr),
    .d    (sclk),
    .q    (unused_sclk_q),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES)) u_cs_sync (
    .clk  (clk),
    .clr  (clr),
    .d    (cs_n),
    .q    (unused_cs_q),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES)) u_mosi_sync (
    .clk  (clk),
    .clr  (clr),
    .d    (mosi),
    .q    (mosi_s),
    .rise (unused_mosi_rise),
    .fall (unused_mosi_fall)
  );

  logic leading, trailing, sample_edge, shift_edge;
  assign leading     = CPOL ? sclk_fall : sclk_rise;
  assign trailing    = CPOL ? sclk_rise : sclk_fall;
  assign sample_edge = SampleLeading ? leading : trailing;
  assign shift_edge  = SampleLeading ? trailing : leading;

  state_e            state_q, state_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0]  tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, hold_q, hold_d;
  logic [WIDTH-1:0]  rx_data_q, rx_data_d;
  logic              hold_full_q, hold_full_d, rx_valid_q, rx_valid_d;
  logic              rx_overrun_q, rx_overrun_d, tx_underrun_q, tx_underrun_d;
  logic              load_pend_q, load_pend_d, skip_shift_q, skip_shift_d;
  logic              do_load, tx_capture;
  logic [WIDTH-1:0]  rx_word;

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    tx_sh_d       = tx_sh_q;
    rx_sh_d       = rx_sh_q;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    load_pend_d   = load_pend_q;
    skip_shift_d  = skip_shift_q;
    rx_overrun_d  = 1'b0;
    tx_underrun_d = 1'b0;
    do_load       = 1'b0;
    rx_word       = '0;
    tx_capture    = tx_valid && !hold_full_q;

    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (cs_fall) begin
          state_d      = StActive;
          do_load      = 1'b1;
          bit_cnt_d    = '0;
          load_pend_d  = 1'b0;
          // Trailing-edge sampling: word is already on miso, first leading edge is a no-op
          skip_shift_d = !SampleLeading;
        end
      end
      StActive: begin
        if (cs_rise) begin
          state_d      = StIdle;
          bit_cnt_d    = '0;
          load_pend_d  = 1'b0;
          skip_shift_d = 1'b0;
          tx_sh_d      = '0;
        end else begin
          if (shift_edge) begin
            if (load_pend_q) begin
              do_load     = 1'b1;
              load_pend_d = 1'b0;
            end else if (skip_shift_q) begin
              skip_shift_d = 1'b0;
            end else begin
              tx_sh_d = MSB_FIRST ? {tx_sh_q[WIDTH-2:0], 1'b0} : {1'b0, tx_sh_q[WIDTH-1:1]};
            end
          end
          if (sample_edge) begin
            rx_word = MSB_FIRST ? {rx_sh_q[WIDTH-2:0], mosi_s} : {mosi_s, rx_sh_q[WIDTH-1:1]};
            rx_sh_d = rx_word;
            if (bit_cnt_q == CntW'(WIDTH - 1)) begin
              bit_cnt_d   = '0;
              load_pend_d = 1'b1;
              if (rx_valid_q && !rx_ready) begin
                rx_overrun_d = 1'b1;
              end else begin
                rx_data_d  = rx_word;
                rx_valid_d = 1'b1;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + CntW'(1);
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // An empty holding register lets a same-cycle capture bypass straight to the shifter
    if (do_load) begin
      if (hold_full_q) begin
        tx_sh_d     = hold_q;
        hold_full_d = 1'b0;
      end else if (tx_capture) begin
        tx_sh_d = tx_data;
      end else begin
        tx_sh_d       = '0;
        tx_underrun_d = 1'b1;
      end
    end else if (tx_capture) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q       <= StIdle;
      bit_cnt_q     <= '0;
      tx_sh_q       <= '0;
      rx_sh_q       <= '0;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      rx_overrun_q  <= 1'b0;
      tx_underrun_q <= 1'b0;
      load_pend_q   <= 1'b0;
      skip_shift_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      tx_sh_q       <= tx_sh_d;
      rx_sh_q       <= rx_sh_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      rx_overrun_q  <= rx_overrun_d;
      tx_underrun_q <= tx_underrun_d;
      load_pend_q   <= load_pend_d;
      skip_shift_q  <= skip_shift_d;
    end
  end

  logic active;
  assign active      = (state_q == StActive);
  assign miso        = active & (MSB_FIRST ? tx_sh_q[WIDTH-1] : tx_sh_q[0]);
  assign miso_oe     = active;
  assign busy        = active;
  assign tx_ready    = ~hold_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_overrun  = rx_overrun_q;
  assign tx_underrun = tx_underrun_q;

endmodule

// File: tb/tb_spi_slave_sync.sv
// Directed bench for spi_slave_sync: four instances (modes 0..3, the mode-3 one LSB-first)
// share one bit-level SPI master.
module tb_spi_slave_sync;

  localparam int H = 8;  // sclk half period in clk cycles
  localparam int Q = 4;  // mosi change offset from sclk edges

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr = 1'b1, cs_n = 1'b1, mosi = 1'b0, phase = 1'b0;
  logic        tx_valid = 1'b0, rx_ready = 1'b0;
  logic [12:0] tx_data = '0;
  logic        sclk_p, sclk_n;
  assign sclk_p = phase;
  assign sclk_n = ~phase;

  logic        miso_a[4], oe_a[4], txr_a[4], rxv_a[4], ovr_a[4], unr_a[4], busy_a[4];
  logic [12:0] rxd_a[4];

  spi_slave_sync #(.WIDTH(13), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1)) dut0 (
    .clk(clk), .clr(clr), .sclk(sclk_p), .cs_n(cs_n), .mosi(mosi), .miso(miso_a[0]),
    .miso_oe(oe_a[0]), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(txr_a[0]),
    .rx_data(rxd_a[0]), .rx_valid(rxv_a[0]), .rx_ready(rx_ready), .rx_overrun(ovr_a[0]),
    .tx_underrun(unr_a[0]), .busy(busy_a[0]));
  spi_slave_sync #(.WIDTH(13), .CPOL(1'b0), .CPHA(1'b1), .MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .clr(clr), .sclk(sclk_p), .cs_n(cs_n), .mosi(mosi), .miso(miso_a[1]),
    .miso_oe(oe_a[1]), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(txr_a[1]),
    .rx_data(rxd_a[1]), .rx_valid(rxv_a[1]), .rx_ready(rx_ready), .rx_overrun(ovr_a[1]),
    .tx_underrun(unr_a[1]), .busy(busy_a[1]));
  spi_slave_sync #(.WIDTH(13), .CPOL(1'b1), .CPHA(1'b0), .MSB_FIRST(1'b1)) dut2 (
    .clk(clk), .clr(clr), .sclk(sclk_n), .cs_n(cs_n), .mosi(mosi), .miso(miso_a[2]),
    .miso_oe(oe_a[2]), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(txr_a[2]),
    .rx_data(rxd_a[2]), .rx_valid(rxv_a[2]), .rx_ready(rx_ready), .rx_overrun(ovr_a[2]),
    .tx_underrun(unr_a[2]), .busy(busy_a[2]));
  spi_slave_sync #(.WIDTH(13), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0)) dut3 (
    .clk(clk), .clr(clr), .sclk(sclk_n), .cs_n(cs_n), .mosi(mosi), .miso(miso_a[3]),
    .miso_oe(oe_a[3]), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(txr_a[3]),
    .rx_data(rxd_a[3]), .rx_valid(rxv_a[3]), .rx_ready(rx_ready), .rx_overrun(ovr_a[3]),
    .tx_underrun(unr_a[3]), .busy(busy_a[3]));

  // Pulse and rx_valid-rise counters per instance
  int   unr_cnt[4] = '{0, 0, 0, 0};
  int   ovr_cnt[4] = '{0, 0, 0, 0};
  int   rxv_cnt[4] = '{0, 0, 0, 0};
  logic rxv_prev[4] = '{1'b0, 1'b0, 1'b0, 1'b0};
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (unr_a[i]) unr_cnt[i] <= unr_cnt[i] + 1;
      if (ovr_a[i]) ovr_cnt[i] <= ovr_cnt[i] + 1;
      if (rxv_a[i] && !rxv_prev[i]) rxv_cnt[i] <= rxv_cnt[i] + 1;
      rxv_prev[i] <= rxv_a[i];
    end
  end

  int          n_cmp = 0, n_err = 0;
  int          u0[4], o0[4], v0[4];
  logic [12:0] rd[4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [12:0] rev13(input logic [12:0] w);
    logic [12:0] r;
    for (int i = 0; i < 13; i++) r[i] = w[12-i];
    return r;
  endfunction

  // Word seen by instance m when the master shifts w out MSB first
  function automatic logic [12:0] exp_rx(input int m, input logic [12:0] w);
    return (m == 3) ? rev13(w) : w;
  endfunction

  function automatic bit cpha0(input int m);
    return (m == 0) || (m == 2);
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    for (int m = 0; m < 4; m++) begin
      u0[m] = unr_cnt[m];
      o0[m] = ovr_cnt[m];
      v0[m] = rxv_cnt[m];
    end
  endtask

  // mosi is held from Q before the leading edge to Q after the trailing edge,
  // so it is valid at the sample edge of every mode
  task automatic xfer_bit(input logic b);
    mosi = b;
    cyc(Q);
    phase = 1'b1;
    rd[0] = {rd[0][11:0], miso_a[0]};
    rd[2] = {rd[2][11:0], miso_a[2]};
    cyc(H);
    phase = 1'b0;
    rd[1] = {rd[1][11:0], miso_a[1]};
    rd[3] = {miso_a[3], rd[3][12:1]};
    cyc(Q);
  endtask

  task automatic send_word(input logic [12:0] w, input int nbits);
    for (int m = 0; m < 4; m++) rd[m] = '0;
    for (int i = 0; i < nbits; i++) xfer_bit(w[12-i]);
    cyc(10);
  endtask

  task automatic push_tx(input logic [12:0] w);
    tx_data  = w;
    tx_valid = 1'b1;
    cyc(1);
    tx_valid = 1'b0;
    cyc(1);
  endtask

  task automatic accept_rx();
    rx_ready = 1'b1;
    cyc(1);
    rx_ready = 1'b0;
    cyc(1);
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    cyc(H);
  endtask

  task automatic cs_high();
    cs_n = 1'b1;
    cyc(H);
  endtask

  task automatic do_reset();
    clr = 1'b1;
    cyc(2);
    clr = 1'b0;
    cyc(6);
  endtask

  initial begin
    // Reset values
    cyc(3);
    clr = 1'b0;
    cyc(6);
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("rst_miso%0d", m), miso_a[m], 0);
      chk($sformatf("rst_oe%0d", m), oe_a[m], 0);
      chk($sformatf("rst_txr%0d", m), txr_a[m], 1);
      chk($sformatf("rst_rxv%0d", m), rxv_a[m], 0);
      chk($sformatf("rst_busy%0d", m), busy_a[m], 0);
      chk($sformatf("rst_rxd%0d", m), rxd_a[m], 0);
      chk($sformatf("rst_pulses%0d", m), {ovr_a[m], unr_a[m]}, 0);
    end

    // Single word: tx 0x1A5B, master sends 0x0F0F; spare tx word avoids the end-of-word underrun
    snap();
    push_tx(13'h1A5B);
    for (int m = 0; m < 4; m++) chk($sformatf("t1_txr_full%0d", m), txr_a[m], 0);
    cs_low();
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("t1_busy%0d", m), busy_a[m], 1);
      chk($sformatf("t1_oe%0d", m), oe_a[m], 1);
      chk($sformatf("t1_txr_load%0d", m), txr_a[m], 1);
    end
    push_tx(13'h0000);
    send_word(13'h0F0F, 13);
    cs_high();
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("t1_read%0d", m), rd[m], 13'h1A5B);
      chk($sformatf("t1_rxd%0d", m), rxd_a[m], exp_rx(m, 13'h0F0F));
      chk($sformatf("t1_rxv%0d", m), rxv_a[m], 1);
      chk($sformatf("t1_unr%0d", m), unr_cnt[m] - u0[m], 0);
      chk($sformatf("t1_ovr%0d", m), ovr_cnt[m] - o0[m], 0);
      chk($sformatf("t1_idle_miso%0d", m), miso_a[m], 0);
    end
    accept_rx();
    for (int m = 0; m < 4; m++) chk($sformatf("t1_rxv_clr%0d", m), rxv_a[m], 0);
    do_reset();

    // Two words per frame, all modes
    snap();
    push_tx(13'h0B3C);
    cs_low();
    push_tx(13'h15A6);
    for (int m = 0; m < 4; m++) chk($sformatf("t2_txr_b%0d", m), txr_a[m], 0);
    send_word(13'h1C71, 13);
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("t2_read_a%0d", m), rd[m], 13'h0B3C);
      chk($sformatf("t2_rxd_a%0d", m), rxd_a[m], exp_rx(m, 13'h1C71));
      chk($sformatf("t2_rxv_a%0d", m), rxv_a[m], 1);
      // Trailing-edge loaders reload at the end of the word, others at the next word's start
      chk($sformatf("t2_txr_mid%0d", m), txr_a[m], cpha0(m));
    end
    accept_rx();
    send_word(13'h0795, 13);
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("t2_read_b%0d", m), rd[m], 13'h15A6);
      chk($sformatf("t2_rxd_b%0d", m), rxd_a[m], exp_rx(m, 13'h0795));
      chk($sformatf("t2_txr_end%0d", m), txr_a[m], 1);
    end
    cs_high();
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("t2_unr%0d", m), unr_cnt[m] - u0[m], cpha0(m) ? 1 : 0);
      chk($sformatf("t2_ovr%0d", m), ovr_cnt[m] - o0[m], 0);
    end
    do_reset();

    // No tx data: miso stays 0, one underrun per load
    snap();
    cs_low();
    send_word(13'h1555, 13);
    for (int m = 0; m < 4; m++) chk($sformatf("t3_read_a%0d", m), rd[m], 0);
    accept_rx();
    send_word(13'h0ABC, 13);
    for (int m = 0; m < 4; m++) chk($sformatf("t3_read_b%0d", m), rd[m], 0);
    cs_high();
    for (int m = 0; m < 4; m++)
      chk($sformatf("t3_unr%0d", m), unr_cnt[m] - u0[m], cpha0(m) ? 3 : 2);
    do_reset();

    // rx_ready held low over two words: first kept, one overrun
    snap();
    push_tx(13'h0001);
    cs_low();
    send_word(13'h0F31, 13);
    send_word(13'h1C0E, 13);
    cs_high();
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("t4_rxd%0d", m), rxd_a[m], exp_rx(m, 13'h0F31));
      chk($sformatf("t4_rxv%0d", m), rxv_a[m], 1);
      chk($sformatf("t4_ovr%0d", m), ovr_cnt[m] - o0[m], 1);
      chk($sformatf("t4_rxv_rise%0d", m), rxv_cnt[m] - v0[m], 1);
    end
    do_reset();

    // Frame aborted after 7 bits, then a full 0x1234 frame
    snap();
    cs_low();
    send_word(13'h1FFF, 7);
    cs_high();
    for (int m = 0; m < 4; m++) chk($sformatf("t5_abort_rxv%0d", m), rxv_a[m], 0);
    cs_low();
    send_word(13'h1234, 13);
    cs_high();
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("t5_rxd%0d", m), rxd_a[m], exp_rx(m, 13'h1234));
      chk($sformatf("t5_rxv_rise%0d", m), rxv_cnt[m] - v0[m], 1);
      chk($sformatf("t5_ovr%0d", m), ovr_cnt[m] - o0[m], 0);
    end
    do_reset();

    // clr at bit 5, then a clean 0x0AAA frame
    snap();
    push_tx(13'h1F0F);
    cs_low();
    send_word(13'h1FFF, 5);
    clr = 1'b1;
    cyc(2);
    clr = 1'b0;
    cyc(1);
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("t6_busy%0d", m), busy_a[m], 0);
      chk($sformatf("t6_oe%0d", m), oe_a[m], 0);
      chk($sformatf("t6_miso%0d", m), miso_a[m], 0);
      chk($sformatf("t6_txr%0d", m), txr_a[m], 1);
      chk($sformatf("t6_rxv%0d", m), rxv_a[m], 0);
    end
    cs_high();
    cs_low();
    send_word(13'h0AAA, 13);
    cs_high();
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("t6_rxd%0d", m), rxd_a[m], exp_rx(m, 13'h0AAA));
      chk($sformatf("t6_rxv_rise%0d", m), rxv_cnt[m] - v0[m], 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
